spi_reg_ctrl: RTL

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller: decodes command frames from spi_slave into register-file reads/writes.
// Optional build macro SPI_REG_CTRL_AUTOINC_EN enables address auto-increment across a burst.
module spi_reg_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic [DWIDTH-1:0] rx_buffer,
  input  logic              rx_dv,
  output logic [DWIDTH-1:0] tx_buffer,
  output logic              wr,
  output logic [AWIDTH-1:0] reg_addr,
  output logic [DWIDTH-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DWIDTH-1:0] reg_rdata,
  output logic              ovr
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, FETCH, LOAD, READ} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] tx_q, tx_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              ovr_q, ovr_d;
  logic              ss_q;

  function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
    return a + AWIDTH'(1);
`else
    return a;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    ovr_d   = 1'b0;
    if (ss) begin
      state_d = IDLE;
    end else begin
      // Address moves on only after the write strobe has been presented with it.
      if (we_q) addr_d = next_addr(addr_q);
      case (state_q)
        IDLE: if (ss_q) state_d = CMD;
        CMD: begin
          if (rx_dv) begin
            addr_d = rx_buffer[AWIDTH-1:0];
            if (rx_buffer[DWIDTH-1]) begin
              state_d = FETCH;
              re_d    = 1'b1;
            end else begin
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          if (rx_dv) begin
            wdata_d = rx_buffer;
            we_d    = 1'b1;
          end
        end
        FETCH: begin
          state_d = LOAD;
          if (rx_dv) ovr_d = 1'b1;
        end
        LOAD: begin
          tx_d    = reg_rdata;
          wr_d    = 1'b1;
          addr_d  = next_addr(addr_q);
          state_d = READ;
          if (rx_dv) ovr_d = 1'b1;
        end
        READ: begin
          if (rx_dv) begin
            state_d = FETCH;
            re_d    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ss_q resets low so a slave-select already held low at reset release is not taken as a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      ovr_q   <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      ovr_q   <= ovr_d;
      ss_q    <= ss;
    end
  end

  assign tx_buffer = tx_q;
  assign wr        = wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign ovr       = ovr_q;

endmodule
